// File: rtl/usb_reg_bridge_pkg.sv
// Shared state encoding and default widths for the SAM3U external-bus to register-bus bridge.
package usb_reg_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_CAP  = 3'd5,
    ST_RELEASE = 3'd6
  } bridge_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_BCNT_WIDTH  = 16;

endpackage

// File: rtl/usb_strobe_sync.sv
// N-stage synchroniser for one active-low pad strobe, plus a one-clock falling-edge pulse.
module usb_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_n,
  output logic level_n,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Idle level of every strobe is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe_n};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign level_n = sync_q[STAGES-1];
  assign fall    = last_q & ~level_n;

endmodule

// File: rtl/usb_reg_bridge.sv
// SAM3U ALEn/CEn/RDn/WRn bus to internal register bus: strobe sync, burst byte counting, read turnaround.
module usb_reg_bridge
  import usb_reg_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int BCNT_WIDTH  = DEF_BCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            usb_d_i,
  output logic [7:0]            usb_d_o,
  output logic                  usb_d_oe,
  input  logic [7:0]            usb_addr_i,
  input  logic                  usb_alen_i,
  input  logic                  usb_cen_i,
  input  logic                  usb_rdn_i,
  input  logic                  usb_wrn_i,
  output logic [ADDR_WIDTH-1:0] reg_address_o,
  output logic [ADDR_WIDTH-1:0] reg_hypaddress_o,
  input  logic [15:0]           reg_hyplen_i,
  output logic [15:0]           reg_size_o,
  output logic [BCNT_WIDTH-1:0] reg_bytecnt_o,
  output logic [7:0]            reg_datao_o,
  input  logic [7:0]            reg_datai_i,
  output logic                  reg_read_o,
  output logic                  reg_write_o,
  output logic                  reg_addrvalid_o,
  output logic                  proto_err_o,
  output logic [2:0]            state_dbg_o
);

  // Handshake: reg_write_o/reg_read_o are single-cycle strobes; reg_datao_o is valid with
  // reg_write_o, and reg_datai_i is sampled in the clock after reg_read_o is raised.

  bridge_state_e state;
  logic [1:0]    rst_sync_q;
  logic          rst_n_s;
  logic          alen_s, cen_s, rdn_s, wrn_s;
  logic          alen_fall, rdn_fall, wrn_fall;
  logic          cen_fall_unused;
  logic          addr_unused;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_alen (
    .clk(clk), .rst_n(rst_n_s), .strobe_n(usb_alen_i), .level_n(alen_s), .fall(alen_fall));
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_cen (
    .clk(clk), .rst_n(rst_n_s), .strobe_n(usb_cen_i), .level_n(cen_s), .fall(cen_fall_unused));
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_rdn (
    .clk(clk), .rst_n(rst_n_s), .strobe_n(usb_rdn_i), .level_n(rdn_s), .fall(rdn_fall));
  usb_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync_wrn (
    .clk(clk), .rst_n(rst_n_s), .strobe_n(usb_wrn_i), .level_n(wrn_s), .fall(wrn_fall));

  assign addr_unused = ^usb_addr_i;

  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state           <= ST_IDLE;
      reg_address_o   <= '0;
      reg_bytecnt_o   <= '0;
      reg_size_o      <= '0;
      reg_datao_o     <= '0;
      usb_d_o         <= '0;
      reg_read_o      <= 1'b0;
      reg_write_o     <= 1'b0;
      reg_addrvalid_o <= 1'b0;
      proto_err_o     <= 1'b0;
    end else begin
      reg_read_o  <= 1'b0;
      reg_write_o <= 1'b0;
      reg_size_o  <= reg_hyplen_i;
      unique case (state)
        ST_IDLE: if (!alen_s && !cen_s) state <= ST_ADDR;
        ST_ADDR: begin
          reg_address_o   <= usb_addr_i[ADDR_WIDTH-1:0];
          reg_bytecnt_o   <= '0;
          reg_addrvalid_o <= 1'b1;
          state           <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cen_s) begin
            reg_addrvalid_o <= 1'b0;
            state           <= ST_IDLE;
          end else if (!rdn_s && !wrn_s) begin
            // Bus contention: no strobe, wait for both to return high.
            proto_err_o <= 1'b1;
            state       <= ST_RELEASE;
          end else if (alen_fall) begin
            state <= ST_ADDR;
          end else if (wrn_fall) begin
            state <= ST_WRITE;
          end else if (rdn_fall) begin
            state <= ST_RD_REQ;
          end
        end
        ST_WRITE: begin
          reg_datao_o <= usb_d_i;
          reg_write_o <= 1'b1;
          state       <= ST_RELEASE;
        end
        ST_RD_REQ: begin
          reg_read_o <= 1'b1;
          state      <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          usb_d_o <= reg_datai_i;
          state   <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (cen_s) begin
            reg_addrvalid_o <= 1'b0;
            state           <= ST_IDLE;
          end else if (rdn_s && wrn_s) begin
            if (reg_bytecnt_o != '1) reg_bytecnt_o <= reg_bytecnt_o + BCNT_WIDTH'(1);
            state <= ST_WAIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign reg_hypaddress_o = reg_address_o;
  assign usb_d_oe         = reset_n & ~usb_cen_i & ~usb_rdn_i & usb_wrn_i;
  assign state_dbg_o      = state;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Randomised scoreboard bench for usb_reg_bridge (4-bit byte counter build to reach saturation quickly).
module tb_usb_reg_bridge;
  import usb_reg_bridge_pkg::*;

  localparam int AW    = 6;
  localparam int BW    = 4;
  localparam int EXP_W = 1 + AW + BW + 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    usb_d_i = '0;
  logic [7:0]    usb_d_o;
  logic          usb_d_oe;
  logic [7:0]    usb_addr_i = '0;
  logic          usb_alen_i = 1'b1, usb_cen_i = 1'b1, usb_rdn_i = 1'b1, usb_wrn_i = 1'b1;
  logic [AW-1:0] reg_address_o, reg_hypaddress_o;
  logic [15:0]   reg_hyplen_i, reg_size_o;
  logic [BW-1:0] reg_bytecnt_o;
  logic [7:0]    reg_datao_o, reg_datai_i;
  logic          reg_read_o, reg_write_o, reg_addrvalid_o, proto_err_o;
  logic [2:0]    state_dbg_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [7:0]       mem[64];
  logic [AW-1:0]    cur_addr;
  int               byte_idx;

  usb_reg_bridge #(.SYNC_STAGES(2), .ADDR_WIDTH(AW), .BCNT_WIDTH(BW)) dut (
    .clk(clk), .reset_n(reset_n), .usb_d_i(usb_d_i), .usb_d_o(usb_d_o), .usb_d_oe(usb_d_oe),
    .usb_addr_i(usb_addr_i), .usb_alen_i(usb_alen_i), .usb_cen_i(usb_cen_i),
    .usb_rdn_i(usb_rdn_i), .usb_wrn_i(usb_wrn_i), .reg_address_o(reg_address_o),
    .reg_hypaddress_o(reg_hypaddress_o), .reg_hyplen_i(reg_hyplen_i), .reg_size_o(reg_size_o),
    .reg_bytecnt_o(reg_bytecnt_o), .reg_datao_o(reg_datao_o), .reg_datai_i(reg_datai_i),
    .reg_read_o(reg_read_o), .reg_write_o(reg_write_o), .reg_addrvalid_o(reg_addrvalid_o),
    .proto_err_o(proto_err_o), .state_dbg_o(state_dbg_o));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  // ---------------- peripheral / reference model ----------------
  function automatic logic [15:0] size_of(input logic [AW-1:0] a);
    return (a < 6'd48) ? 16'(a) * 16'd3 + 16'd1 : 16'd0;
  endfunction

  function automatic int sat_idx(input int i);
    return (i > 15) ? 15 : i;
  endfunction

  function automatic logic [EXP_W-1:0] pack_exp(input logic rd, input logic [AW-1:0] a,
                                                input logic [BW-1:0] bc, input logic [7:0] d);
    return {rd, a, bc, d};
  endfunction

  assign reg_hyplen_i = size_of(reg_hypaddress_o);
  assign reg_datai_i  = mem[reg_address_o] + 8'(reg_bytecnt_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " reg_address"}, 32'(reg_address_o), 0);
    check({tag, " reg_hypaddress"}, 32'(reg_hypaddress_o), 0);
    check({tag, " reg_size"}, 32'(reg_size_o), 0);
    check({tag, " reg_bytecnt"}, 32'(reg_bytecnt_o), 0);
    check({tag, " reg_datao"}, 32'(reg_datao_o), 0);
    check({tag, " read/write"}, {30'd0, reg_read_o, reg_write_o}, 0);
    check({tag, " addrvalid"}, 32'(reg_addrvalid_o), 0);
    check({tag, " proto_err"}, 32'(proto_err_o), 0);
    check({tag, " usb_d_o"}, 32'(usb_d_o), 0);
    check({tag, " usb_d_oe"}, 32'(usb_d_oe), 0);
    check({tag, " state"}, 32'(state_dbg_o), 32'(ST_IDLE));
  endtask

  // ---------------- host driver tasks ----------------
  task automatic bus_addr(input logic [AW-1:0] a);
    usb_cen_i  = 1'b0;
    usb_alen_i = 1'b0;
    usb_addr_i = {$urandom_range(0, 3) % 4 == 0 ? 2'b11 : 2'b00, a};
    clks(5);
    usb_alen_i = 1'b1;
    clks(2);
    cur_addr = a;
    byte_idx = 0;
    check("addr latch", 32'(reg_address_o), 32'(a));
    check("hypaddress", 32'(reg_hypaddress_o), 32'(a));
    check("reg_size", 32'(reg_size_o), 32'(size_of(a)));
    check("addrvalid set", 32'(reg_addrvalid_o), 1);
    check("bytecnt after ale", 32'(reg_bytecnt_o), 0);
  endtask

  task automatic bus_write(input logic [7:0] d);
    exp_q.push_back(pack_exp(1'b0, cur_addr, BW'(sat_idx(byte_idx)), d));
    usb_d_i   = d;
    usb_wrn_i = 1'b0;
    clks(6);
    check("oe during write", 32'(usb_d_oe), 0);
    usb_wrn_i = 1'b1;
    usb_d_i   = 8'($urandom_range(0, 255));
    clks(4);
    byte_idx++;
  endtask

  task automatic bus_read();
    int bc;
    bc = sat_idx(byte_idx);
    exp_q.push_back(pack_exp(1'b1, cur_addr, BW'(bc), mem[cur_addr] + 8'(bc)));
    usb_rdn_i = 1'b0;
    clks(6);
    check("oe during read", 32'(usb_d_oe), 1);
    usb_rdn_i = 1'b1;
    #1;
    check("oe after rdn high", 32'(usb_d_oe), 0);
    clks(4);
    byte_idx++;
  endtask

  task automatic bus_end();
    usb_cen_i = 1'b1;
    clks(4);
    check("addrvalid cleared", 32'(reg_addrvalid_o), 0);
    check("idle after cen", 32'(state_dbg_o), 32'(ST_IDLE));
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [EXP_W-1:0] e;
    logic             rd_pending;
    logic [7:0]       rd_exp;
    rd_pending = 1'b0;
    rd_exp     = '0;
    forever begin
      @(negedge clk);
      if (rd_pending) begin
        check("read data", 32'(usb_d_o), 32'(rd_exp));
        rd_pending = 1'b0;
      end
      if (reg_write_o || reg_read_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected strobe: write=%0b read=%0b addr=0x%0h bytecnt=%0d required none",
                   reg_write_o, reg_read_o, reg_address_o, reg_bytecnt_o);
        end else begin
          e = exp_q.pop_front();
          if (reg_write_o) begin
            check("write strobe", 32'(pack_exp(reg_read_o, reg_address_o, reg_bytecnt_o, reg_datao_o)),
                  32'(e));
          end else begin
            check("read strobe", 32'({1'b1, reg_address_o, reg_bytecnt_o}), 32'(e[EXP_W-1:8]));
            rd_exp     = e[7:0];
            rd_pending = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int len;
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[6'h15] = 8'hA7;
    cur_addr = '0;
    byte_idx = 0;

    clks(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    clks(4);

    // single write
    bus_addr(6'h2A);
    bus_write(8'h5C);
    check("datao hold", 32'(reg_datao_o), 32'h5C);
    bus_end();

    // 4-byte burst, then re-address inside the same CEn window
    bus_addr(6'h11);
    for (int i = 0; i < 4; i++) bus_write(8'($urandom_range(0, 255)));
    check("bytecnt after burst", 32'(reg_bytecnt_o), 4);
    bus_addr(6'h11);
    bus_write(8'($urandom_range(0, 255)));
    bus_end();

    // read returning 0xA7, pad data held after the cycle
    bus_addr(6'h15);
    bus_read();
    bus_end();
    check("usb_d_o holds", 32'(usb_d_o), 32'hA7);

    // CEn released while byte 2 is still in RELEASE
    bus_addr(6'h07);
    bus_write(8'h01);
    bus_write(8'h02);
    exp_q.push_back(pack_exp(1'b0, 6'h07, BW'(2), 8'h03));
    usb_d_i   = 8'h03;
    usb_wrn_i = 1'b0;
    clks(6);
    usb_cen_i = 1'b1;
    clks(5);
    check("abort addrvalid", 32'(reg_addrvalid_o), 0);
    check("abort bytecnt", 32'(reg_bytecnt_o), 2);
    check("abort state", 32'(state_dbg_o), 32'(ST_IDLE));
    usb_wrn_i = 1'b1;
    clks(3);

    // RDn and WRn low together
    bus_addr(6'h30);
    usb_rdn_i = 1'b0;
    usb_wrn_i = 1'b0;
    clks(6);
    check("proto_err set", 32'(proto_err_o), 1);
    check("oe with both low", 32'(usb_d_oe), 0);
    usb_rdn_i = 1'b1;
    usb_wrn_i = 1'b1;
    clks(4);
    byte_idx++;
    bus_write(8'($urandom_range(0, 255)));
    bus_read();
    bus_end();

    // random traffic
    for (int t = 0; t < 20; t++) begin
      bus_addr(AW'($urandom_range(0, 63)));
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 1) == 1) bus_write(8'($urandom_range(0, 255)));
        else bus_read();
      end
      bus_end();
    end
    check("proto_err sticky", 32'(proto_err_o), 1);

    // reset pulse in the middle of a read, before any strobe
    bus_addr(6'h09);
    usb_rdn_i = 1'b0;
    clks(2);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid-read reset");
    clks(2);
    usb_rdn_i = 1'b1;
    usb_cen_i = 1'b1;
    reset_n   = 1'b1;
    clks(4);
    check("idle after reset", 32'(state_dbg_o), 32'(ST_IDLE));

    // 17-byte burst saturates the 4-bit counter
    bus_addr(6'h3C);
    for (int i = 0; i < 17; i++) bus_write(8'($urandom_range(0, 255)));
    check("bytecnt saturated", 32'(reg_bytecnt_o), 15);
    bus_end();

    clks(4);
    check("scoreboard drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
